// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter and single-outstanding instruction-cache fetch stage
// Optional misaligned-redirect fault handling: define IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pc_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic        icache_rsp_valid,
    input  logic [31:0] icache_rsp_data,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    output logic        misalign_fault
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
`ifdef IFU_MISALIGN_CHECK_EN
        ST_HOLD,
        ST_FAULT
`else
        ST_HOLD
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic [31:0] ins_q;
    logic [31:0] ins_pc_q;
    logic [31:0] redirect_target;
    logic [31:0] pc_next_seq;

    assign pc_next_seq = pc + 32'd4;

`ifdef IFU_MISALIGN_CHECK_EN
    logic redirect_bad;
    logic fault_q;

    // A misaligned target is never loaded; it diverts the stage into FAULT instead.
    assign redirect_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_target = redirect_pc;
    assign misalign_fault  = fault_q;
`else
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign misalign_fault  = 1'b0;
`endif

    // Outputs come from registers or the state decode only, never straight from inputs.
    assign icache_req  = (state == ST_REQ);
    assign icache_addr = pc;
    assign ins_valid   = (state == ST_HOLD);
    assign ins         = ins_q;
    assign ins_pc      = ins_pc_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            ins_q    <= 32'd0;
            ins_pc_q <= 32'd0;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                end

                ST_REQ: begin
`ifdef IFU_MISALIGN_CHECK_EN
                    if (redirect_bad) begin
                        fault_q <= 1'b1;
                        drop    <= 1'b0;
                        state   <= ST_FAULT;
                    end else
`endif
                    begin
                        if (redirect_valid) begin
                            pc <= redirect_target;
                        end
                        // An address accepted alongside a redirect is stale, so its data is dropped.
                        if (icache_ready) begin
                            drop  <= redirect_valid;
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
`ifdef IFU_MISALIGN_CHECK_EN
                    if (redirect_bad) begin
                        fault_q <= 1'b1;
                        drop    <= 1'b0;
                        state   <= ST_FAULT;
                    end else
`endif
                    if (icache_rsp_valid) begin
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= ST_REQ;
                            if (redirect_valid) begin
                                pc <= redirect_target;
                            end
                        end else begin
                            ins_q    <= icache_rsp_data;
                            ins_pc_q <= pc;
                            state    <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pc   <= redirect_target;
                        drop <= 1'b1;
                    end
                end

                ST_HOLD: begin
`ifdef IFU_MISALIGN_CHECK_EN
                    if (redirect_bad) begin
                        fault_q  <= 1'b1;
                        ins_q    <= 32'd0;
                        ins_pc_q <= 32'd0;
                        state    <= ST_FAULT;
                    end else
`endif
                    if (redirect_valid) begin
                        pc       <= redirect_target;
                        ins_q    <= 32'd0;
                        ins_pc_q <= 32'd0;
                        state    <= ST_REQ;
                    end else if (pc_en) begin
                        pc       <= pc_next_seq;
                        ins_q    <= 32'd0;
                        ins_pc_q <= 32'd0;
                        state    <= ST_REQ;
                    end
                end

`ifdef IFU_MISALIGN_CHECK_EN
                // Terminal until reset; any late response is simply never consumed.
                ST_FAULT: begin
                    drop <= 1'b0;
                end
`endif

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        pc_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        icache_ready;
    logic        icache_rsp_valid;
    logic [31:0] icache_rsp_data;

    logic        icache_req,   w_icache_req;
    logic [31:0] icache_addr,  w_icache_addr;
    logic [31:0] ins,          w_ins;
    logic [31:0] ins_pc,       w_ins_pc;
    logic        ins_valid,    w_ins_valid;
    logic        misalign_fault, w_misalign_fault;

    int total = 0;
    int bad   = 0;

    instruction_fetch_unit dut (
        .clk              (clk),
        .rstn             (rstn),
        .pc_en            (pc_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .icache_req       (icache_req),
        .icache_addr      (icache_addr),
        .icache_ready     (icache_ready),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .ins              (ins),
        .ins_pc           (ins_pc),
        .ins_valid        (ins_valid),
        .misalign_fault   (misalign_fault)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk              (clk),
        .rstn             (rstn),
        .pc_en            (pc_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .icache_req       (w_icache_req),
        .icache_addr      (w_icache_addr),
        .icache_ready     (icache_ready),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .ins              (w_ins),
        .ins_pc           (w_ins_pc),
        .ins_valid        (w_ins_valid),
        .misalign_fault   (w_misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From REQ: accept the request, return data one cycle later, end in HOLD.
    task automatic fetch(input logic [31:0] data);
        icache_ready = 1'b1;
        tick();
        icache_ready     = 1'b0;
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = data;
        tick();
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = 32'd0;
    endtask

    initial begin
        rstn             = 1'b0;
        pc_en            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'd0;
        icache_ready     = 1'b0;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = 32'd0;
        tick();
        tick();
        check("rst_req",   {31'd0, icache_req}, 32'd0);
        check("rst_addr",  icache_addr, 32'd0);
        check("rst_ins",   ins, 32'd0);
        check("rst_inspc", ins_pc, 32'd0);
        check("rst_valid", {31'd0, ins_valid}, 32'd0);
        check("rst_fault", {31'd0, misalign_fault}, 32'd0);
        check("rst_waddr", w_icache_addr, 32'hFFFF_FFFC);

        rstn = 1'b1;
        tick();
        check("first_req",  {31'd0, icache_req}, 32'd1);
        check("first_addr", icache_addr, 32'd0);

        icache_ready = 1'b1;
        tick();
        icache_ready = 1'b0;
        check("wait_noreq", {31'd0, icache_req}, 32'd0);
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 32'h0000_0093;
        tick();
        icache_rsp_valid = 1'b0;
        check("h0_valid", {31'd0, ins_valid}, 32'd1);
        check("h0_ins",   ins, 32'h0000_0093);
        check("h0_pc",    ins_pc, 32'd0);

        pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
        check("seq_addr4",  icache_addr, 32'd4);
        check("seq_req",    {31'd0, icache_req}, 32'd1);
        check("seq_inv",    {31'd0, ins_valid}, 32'd0);
        check("seq_ins0",   ins, 32'd0);
        check("wrap_addr",  w_icache_addr, 32'd0);

        fetch(32'h0000_0093);
        check("h1_ins", ins, 32'h0000_0093);
        check("h1_pc",  ins_pc, 32'd4);

        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'd0, ins_valid}, 32'd1);
            check("stall_pc",    ins_pc, 32'd4);
            check("stall_req",   {31'd0, icache_req}, 32'd0);
            check("stall_addr",  icache_addr, 32'd4);
        end
        pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
        check("after_stall_addr", icache_addr, 32'd8);

        // Redirect while a request is outstanding; its response must be discarded.
        icache_ready = 1'b1;
        tick();
        icache_ready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid   = 1'b0;
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 32'hDEAD_BEEF;
        tick();
        icache_rsp_valid = 1'b0;
        check("drop_valid", {31'd0, ins_valid}, 32'd0);
        check("drop_ins",   ins, 32'd0);
        check("drop_req",   {31'd0, icache_req}, 32'd1);
        check("drop_addr",  icache_addr, 32'h100);
        fetch(32'h0000_0013);
        check("rd_ins", ins, 32'h0000_0013);
        check("rd_pc",  ins_pc, 32'h100);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        pc_en          = 1'b1;
        tick();
        redirect_valid = 1'b0;
        pc_en          = 1'b0;
        check("hold_rd_addr",  icache_addr, 32'h200);
        check("hold_rd_valid", {31'd0, ins_valid}, 32'd0);

        // Redirect in the same cycle the request is accepted.
        icache_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        icache_ready     = 1'b0;
        redirect_valid   = 1'b0;
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = 32'h1111_1111;
        tick();
        icache_rsp_valid = 1'b0;
        check("stale_valid", {31'd0, ins_valid}, 32'd0);
        check("stale_addr",  icache_addr, 32'h300);
        check("stale_req",   {31'd0, icache_req}, 32'd1);
        fetch(32'h2222_2222);
        check("stale_ins", ins, 32'h2222_2222);
        check("stale_pc",  ins_pc, 32'h300);
        pc_en = 1'b1;
        tick();
        pc_en = 1'b0;
        check("pre_mis_addr", icache_addr, 32'h304);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        check("mis_fault", {31'd0, misalign_fault}, 32'd1);
        check("mis_req",   {31'd0, icache_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            icache_ready = 1'b1;
            tick();
            check("mis_sticky", {31'd0, misalign_fault}, 32'd1);
            check("mis_noreq",  {31'd0, icache_req}, 32'd0);
            check("mis_noins",  {31'd0, ins_valid}, 32'd0);
        end
        icache_ready = 1'b0;
`else
        check("mis_fault", {31'd0, misalign_fault}, 32'd0);
        check("mis_addr",  icache_addr, 32'h100);
        check("mis_req",   {31'd0, icache_req}, 32'd1);
`endif

        // Asynchronous reset mid-operation takes effect without a clock edge.
        rstn = 1'b0;
        #1;
        check("async_addr",  icache_addr, 32'd0);
        check("async_req",   {31'd0, icache_req}, 32'd0);
        check("async_fault", {31'd0, misalign_fault}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
